// File: rtl/ysyx_22040237_pkg.sv
// Shared decode constants for the ID stage: internal opcodes, immediate
// formats, operand selects and RISC-V major-opcode field values.
package ysyx_22040237_pkg;

  localparam logic [7:0] OPC_NOP   = 8'h00;
  localparam logic [7:0] OPC_ADD   = 8'h11;
  localparam logic [7:0] OPC_SUB   = 8'h12;
  localparam logic [7:0] OPC_SLL   = 8'h13;
  localparam logic [7:0] OPC_SLT   = 8'h14;
  localparam logic [7:0] OPC_SLTU  = 8'h15;
  localparam logic [7:0] OPC_XOR   = 8'h16;
  localparam logic [7:0] OPC_SRL   = 8'h17;
  localparam logic [7:0] OPC_SRA   = 8'h18;
  localparam logic [7:0] OPC_OR    = 8'h19;
  localparam logic [7:0] OPC_AND   = 8'h1A;
  localparam logic [7:0] OPC_JAL   = 8'h30;
  localparam logic [7:0] OPC_JALR  = 8'h31;
  localparam logic [7:0] OPC_ADDIW = 8'h41;
  localparam logic [7:0] OPC_SLLIW = 8'h42;
  localparam logic [7:0] OPC_SRLIW = 8'h43;
  localparam logic [7:0] OPC_SRAIW = 8'h44;
  localparam logic [7:0] OPC_ADDW  = 8'h45;
  localparam logic [7:0] OPC_SUBW  = 8'h46;
  localparam logic [7:0] OPC_SLLW  = 8'h47;
  localparam logic [7:0] OPC_SRLW  = 8'h48;
  localparam logic [7:0] OPC_SRAW  = 8'h49;

  localparam logic [6:0] RV_OP_IMM   = 7'b0010011;
  localparam logic [6:0] RV_OP       = 7'b0110011;
  localparam logic [6:0] RV_LUI      = 7'b0110111;
  localparam logic [6:0] RV_AUIPC    = 7'b0010111;
  localparam logic [6:0] RV_JAL      = 7'b1101111;
  localparam logic [6:0] RV_JALR     = 7'b1100111;
  localparam logic [6:0] RV_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] RV_OP32     = 7'b0111011;

  typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_U, FMT_J} fmt_e;
  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

  // Shared funct3 -> ALU opcode map for OP and OP-IMM; alt selects SUB/SRA.
  function automatic logic [7:0] alu_opc(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_opc = alt ? OPC_SUB : OPC_ADD;
      3'b001:  alu_opc = OPC_SLL;
      3'b010:  alu_opc = OPC_SLT;
      3'b011:  alu_opc = OPC_SLTU;
      3'b100:  alu_opc = OPC_XOR;
      3'b101:  alu_opc = alt ? OPC_SRA : OPC_SRL;
      3'b110:  alu_opc = OPC_OR;
      default: alu_opc = OPC_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040237_imm_gen.sv
// Immediate extraction and sign extension to XLEN for I/U/J formats;
// R-type and undecoded instructions yield zero.
module ysyx_22040237_imm_gen
  import ysyx_22040237_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [11:0] imm_i;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  assign imm_i = inst[31:20];
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Size casts of signed values sign-extend, which also covers XLEN=32.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = XLEN'(imm_i);
      FMT_U:   imm = XLEN'(imm_u);
      FMT_J:   imm = XLEN'(imm_j);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_id_stage.sv
// RV32I/RV64I integer decode stage with a one-entry valid/ready output
// register. Define YSYX_22040237_RV64W_EN (with XLEN=64) to decode the *W ops.
module ysyx_22040237_id_stage
  import ysyx_22040237_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            rs1_r_en,
  output logic            rs2_r_en,
  output logic [4:0]      rs1_r_addr,
  output logic [4:0]      rs2_r_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  inst_opcode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] out_pc,
  output logic            rd_w_en,
  output logic [4:0]      rd_w_addr,
  output logic            illegal
);

  logic [6:0] opf;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] funct6;
  logic       shamt_ok, sh_lo, sh_ra;

  assign opf    = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign funct6 = inst[31:26];
  // On RV32 shamt[5] (inst[25]) must be zero for the shift to be legal.
  assign shamt_ok = (XLEN == 64) || !inst[25];
  assign sh_lo    = (funct6 == 6'b000000) && shamt_ok;
  assign sh_ra    = (funct6 == 6'b010000) && shamt_ok;

  logic       legal, rs1_en, rs2_en, rd_en;
  logic [7:0] dec_opc;
  fmt_e       fmt;
  op1_sel_e   op1_sel;
  op2_sel_e   op2_sel;

  always_comb begin
    legal   = 1'b0;
    rs1_en  = 1'b0;
    rs2_en  = 1'b0;
    rd_en   = 1'b0;
    dec_opc = OPC_NOP;
    fmt     = FMT_NONE;
    op1_sel = OP1_ZERO;
    op2_sel = OP2_ZERO;
    case (opf)
      RV_OP_IMM: begin
        fmt = FMT_I; rs1_en = 1'b1; rd_en = 1'b1;
        op1_sel = OP1_RS1; op2_sel = OP2_IMM;
        dec_opc = alu_opc(funct3, (funct3 == 3'b101) && inst[30]);
        case (funct3)
          3'b001:  legal = sh_lo;
          3'b101:  legal = sh_lo || sh_ra;
          default: legal = 1'b1;
        endcase
      end
      RV_OP: begin
        fmt = FMT_R; rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1;
        op1_sel = OP1_RS1; op2_sel = OP2_RS2;
        dec_opc = alu_opc(funct3, inst[30]);
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      RV_LUI: begin
        legal = 1'b1; fmt = FMT_U; rd_en = 1'b1; dec_opc = OPC_ADD;
        op1_sel = OP1_ZERO; op2_sel = OP2_IMM;
      end
      RV_AUIPC: begin
        legal = 1'b1; fmt = FMT_U; rd_en = 1'b1; dec_opc = OPC_ADD;
        op1_sel = OP1_PC; op2_sel = OP2_IMM;
      end
      RV_JAL: begin
        legal = 1'b1; fmt = FMT_J; rd_en = 1'b1; dec_opc = OPC_JAL;
        op1_sel = OP1_PC; op2_sel = OP2_FOUR;
      end
      RV_JALR: begin
        legal = (funct3 == 3'b000); fmt = FMT_I; rs1_en = 1'b1; rd_en = 1'b1;
        dec_opc = OPC_JALR; op1_sel = OP1_PC; op2_sel = OP2_FOUR;
      end
`ifdef YSYX_22040237_RV64W_EN
      RV_OP_IMM32: if (XLEN == 64) begin
        fmt = FMT_I; rs1_en = 1'b1; rd_en = 1'b1;
        op1_sel = OP1_RS1; op2_sel = OP2_IMM;
        case (funct3)
          3'b000: begin legal = 1'b1; dec_opc = OPC_ADDIW; end
          3'b001: begin legal = (funct7 == 7'b0000000); dec_opc = OPC_SLLIW; end
          3'b101: begin
            legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_opc = inst[30] ? OPC_SRAIW : OPC_SRLIW;
          end
          default: legal = 1'b0;
        endcase
      end
      RV_OP32: if (XLEN == 64) begin
        fmt = FMT_R; rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1;
        op1_sel = OP1_RS1; op2_sel = OP2_RS2;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: begin legal = 1'b1; dec_opc = OPC_ADDW; end
          {7'b0100000, 3'b000}: begin legal = 1'b1; dec_opc = OPC_SUBW; end
          {7'b0000000, 3'b001}: begin legal = 1'b1; dec_opc = OPC_SLLW; end
          {7'b0000000, 3'b101}: begin legal = 1'b1; dec_opc = OPC_SRLW; end
          {7'b0100000, 3'b101}: begin legal = 1'b1; dec_opc = OPC_SRAW; end
          default:              legal = 1'b0;
        endcase
      end
`endif
      default: legal = 1'b0;
    endcase
    // Anything unsupported collapses to a side-effect-free NOP.
    if (!legal) begin
      rs1_en = 1'b0; rs2_en = 1'b0; rd_en = 1'b0; dec_opc = OPC_NOP;
      fmt = FMT_NONE; op1_sel = OP1_ZERO; op2_sel = OP2_ZERO;
    end
  end

  logic [XLEN-1:0] imm_w;

  ysyx_22040237_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm_w)
  );

  assign rs1_r_en   = rs1_en && !rst;
  assign rs2_r_en   = rs2_en && !rst;
  assign rs1_r_addr = rs1_r_en ? inst[19:15] : 5'd0;
  assign rs2_r_addr = rs2_r_en ? inst[24:20] : 5'd0;

  logic [XLEN-1:0] op1_w, op2_w;
  logic            rd_en_w;

  always_comb begin
    op1_w = '0;
    op2_w = '0;
    case (op1_sel)
      OP1_RS1: op1_w = rs1_data;
      OP1_PC:  op1_w = pc;
      default: op1_w = '0;
    endcase
    case (op2_sel)
      OP2_RS2:  op2_w = rs2_data;
      OP2_IMM:  op2_w = imm_w;
      OP2_FOUR: op2_w = XLEN'(4);
      default:  op2_w = '0;
    endcase
  end

  assign rd_en_w = rd_en && (inst[11:7] != 5'd0);

  logic            out_valid_q, out_valid_d;
  logic [OPW-1:0]  inst_opcode_q, inst_opcode_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d, out_pc_q, out_pc_d;
  logic            rd_w_en_q, rd_w_en_d, illegal_q, illegal_d;
  logic [4:0]      rd_w_addr_q, rd_w_addr_d;
  logic            xfer;

  assign in_ready = rst || !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    inst_opcode_d = inst_opcode_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    imm_d         = imm_q;
    out_pc_d      = out_pc_q;
    rd_w_en_d     = rd_w_en_q;
    rd_w_addr_d   = rd_w_addr_q;
    illegal_d     = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d   = 1'b1;
      inst_opcode_d = OPW'(dec_opc);
      op1_d         = op1_w;
      op2_d         = op2_w;
      imm_d         = imm_w;
      out_pc_d      = pc;
      rd_w_en_d     = rd_en_w;
      rd_w_addr_d   = rd_en_w ? inst[11:7] : 5'd0;
      illegal_d     = !legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      inst_opcode_q <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      imm_q         <= '0;
      out_pc_q      <= '0;
      rd_w_en_q     <= 1'b0;
      rd_w_addr_q   <= 5'd0;
      illegal_q     <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      inst_opcode_q <= inst_opcode_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      imm_q         <= imm_d;
      out_pc_q      <= out_pc_d;
      rd_w_en_q     <= rd_w_en_d;
      rd_w_addr_q   <= rd_w_addr_d;
      illegal_q     <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign inst_opcode = inst_opcode_q;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign imm         = imm_q;
  assign out_pc      = out_pc_q;
  assign rd_w_en     = rd_w_en_q;
  assign rd_w_addr   = rd_w_addr_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_ysyx_22040237_id_stage.sv
// Scoreboard bench for the ID stage: expected decode records are queued on
// each accepted instruction and compared when the output register updates.
module tb_ysyx_22040237_id_stage;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst;
  logic [63:0] pc, rs1_data, rs2_data, op1, op2, imm, out_pc;
  logic        rs1_r_en, rs2_r_en, rd_w_en, illegal;
  logic [4:0]  rs1_r_addr, rs2_r_addr, rd_w_addr;
  logic [7:0]  inst_opcode;

  ysyx_22040237_id_stage #(.XLEN(64), .OPW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_r_en(rs1_r_en), .rs2_r_en(rs2_r_en),
    .rs1_r_addr(rs1_r_addr), .rs2_r_addr(rs2_r_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .inst_opcode(inst_opcode),
    .op1(op1), .op2(op2), .imm(imm), .out_pc(out_pc),
    .rd_w_en(rd_w_en), .rd_w_addr(rd_w_addr), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, rs1, rs2;
    logic        r1en; logic [4:0] r1a;
    logic        r2en; logic [4:0] r2a;
    logic [7:0]  opc;
    logic [63:0] op1, op2, imm;
    logic        rden; logic [4:0] rda;
    logic        ill;
  } vec_t;

  vec_t tv[13];
  vec_t sb_q[$];
  vec_t last;
  int   checks = 0;
  int   fails  = 0;
  logic mdl_valid;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic cmp_out(input vec_t e);
    chk("opcode", 64'(inst_opcode), 64'(e.opc));
    chk("rd_w_en", 64'(rd_w_en), 64'(e.rden));
    chk("rd_w_addr", 64'(rd_w_addr), 64'(e.rda));
    chk("illegal", 64'(illegal), 64'(e.ill));
    chk("out_pc", out_pc, e.pc);
    if (!e.ill) begin
      chk("op1", op1, e.op1);
      chk("op2", op2, e.op2);
      chk("imm", imm, e.imm);
    end
  endtask

  // One clock: drive, check comb outputs, then check the registered result.
  task automatic step(input logic v, input int idx, input logic ordy, input logic fl);
    logic exp_rdy, xfer;
    vec_t e;
    e = tv[idx];
    in_valid = v; inst = e.inst; pc = e.pc; rs1_data = e.rs1; rs2_data = e.rs2;
    out_ready = ordy; flush = fl;
    #2;
    exp_rdy = !mdl_valid || ordy;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (v && !e.ill) begin
      chk("rs1_r_en", 64'(rs1_r_en), 64'(e.r1en));
      chk("rs1_r_addr", 64'(rs1_r_addr), 64'(e.r1a));
      chk("rs2_r_en", 64'(rs2_r_en), 64'(e.r2en));
      chk("rs2_r_addr", 64'(rs2_r_addr), 64'(e.r2a));
    end
    xfer = v && exp_rdy && !fl;
    if (xfer) sb_q.push_back(e);
    @(posedge clk); #1;
    if (fl) mdl_valid = 1'b0;
    else if (v && exp_rdy) mdl_valid = 1'b1;
    else if (ordy) mdl_valid = 1'b0;
    chk("out_valid", 64'(out_valid), 64'(mdl_valid));
    if (xfer) begin
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty act=0 exp=1");
      end else begin
        last = sb_q.pop_front();
      end
    end
    cmp_out(last);
  endtask

  initial begin
    tv[0]  = '{32'h00500093, 64'h1000, 64'd0, 64'd0, 1'b1, 5'd0, 1'b0, 5'd0,
               8'h11, 64'd0, 64'd5, 64'd5, 1'b1, 5'd1, 1'b0};
    tv[1]  = '{32'hFFF08113, 64'h1004, 64'd7, 64'd0, 1'b1, 5'd1, 1'b0, 5'd0,
               8'h11, 64'd7, '1, '1, 1'b1, 5'd2, 1'b0};
    tv[2]  = '{32'h402081B3, 64'h1008, 64'h10, 64'd3, 1'b1, 5'd1, 1'b1, 5'd2,
               8'h12, 64'h10, 64'd3, 64'd0, 1'b1, 5'd3, 1'b0};
    tv[3]  = '{32'h123452B7, 64'h100C, 64'hDEAD, 64'hBEEF, 1'b0, 5'd0, 1'b0, 5'd0,
               8'h11, 64'd0, 64'h12345000, 64'h12345000, 1'b1, 5'd5, 1'b0};
    tv[4]  = '{32'hFFFFF317, 64'h2000, 64'hDEAD, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0,
               8'h11, 64'h2000, 64'hFFFFFFFFFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b1, 5'd6, 1'b0};
    tv[5]  = '{32'h008000EF, 64'h3000, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0,
               8'h30, 64'h3000, 64'd4, 64'd8, 1'b1, 5'd1, 1'b0};
    tv[6]  = '{32'h00008067, 64'h3004, 64'h5555, 64'd0, 1'b1, 5'd1, 1'b0, 5'd0,
               8'h31, 64'h3004, 64'd4, 64'd0, 1'b0, 5'd0, 1'b0};
`ifdef YSYX_22040237_RV64W_EN
    tv[7]  = '{32'h0010809B, 64'h3008, 64'h20, 64'd0, 1'b1, 5'd1, 1'b0, 5'd0,
               8'h41, 64'h20, 64'd1, 64'd1, 1'b1, 5'd1, 1'b0};
`else
    tv[7]  = '{32'h0010809B, 64'h3008, 64'h20, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0,
               8'h00, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b1};
`endif
    tv[8]  = '{32'h409453B3, 64'h300C, 64'h8000000000000000, 64'd9, 1'b1, 5'd8, 1'b1, 5'd9,
               8'h18, 64'h8000000000000000, 64'd9, 64'd0, 1'b1, 5'd7, 1'b0};
    tv[9]  = '{32'h4215D513, 64'h3010, 64'h123, 64'd0, 1'b1, 5'd11, 1'b0, 5'd0,
               8'h18, 64'h123, 64'h421, 64'h421, 1'b1, 5'd10, 1'b0};
    tv[10] = '{32'h00000000, 64'h3014, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0,
               8'h00, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b1};
    tv[11] = '{32'h0062B233, 64'h3018, 64'd1, 64'd2, 1'b1, 5'd5, 1'b1, 5'd6,
               8'h15, 64'd1, 64'd2, 64'd0, 1'b1, 5'd4, 1'b0};
    tv[12] = '{32'h00208033, 64'h301C, 64'd3, 64'd4, 1'b1, 5'd1, 1'b1, 5'd2,
               8'h11, 64'd3, 64'd4, 64'd0, 1'b0, 5'd0, 1'b0};
    last = '{32'd0, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0,
             8'h00, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0};

    // Reset with a valid addi and flush both presented: reset must win.
    rst = 1'b1; in_valid = 1'b1; inst = tv[1].inst; pc = tv[1].pc;
    rs1_data = 64'h77; rs2_data = 64'h0; out_ready = 1'b0; flush = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_rs1_r_en", 64'(rs1_r_en), 64'd0);
    chk("rst_rs1_r_addr", 64'(rs1_r_addr), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    cmp_out(last);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    mdl_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) step(1'b1, i, 1'b1, 1'b0);
    // Back-pressure: three stalled cycles then acceptance.
    step(1'b1, 4, 1'b1, 1'b0);
    repeat (3) step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b0);
    step(1'b1, 6, 1'b1, 1'b0);
    // Flush while holding with a new instruction offered.
    step(1'b1, 7, 1'b0, 1'b1);
    for (int i = 7; i < 13; i++) step(1'b1, i, 1'b1, 1'b0);
    // Held valid with no new input, then drain.
    step(1'b1, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover act=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
